// File: rtl/gatebach_feeder_if.sv
// Host and core-bus signal bundle for gatebach_feeder.
// The feeder takes the slave modport; the host/core environment takes master.
interface gatebach_feeder_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              start;
    logic              prime_valid;
    logic [DATA_W-1:0] prime_data;
    logic              prime_ready;
    logic              core_cs_in;
    logic [ADDR_W-1:0] core_add_in;
    logic [DATA_W-1:0] core_data_in;
    logic              core_proc_done;
    logic              core_cs_out;
    logic [ADDR_W-1:0] core_add_out;
    logic [DATA_W-1:0] core_data_out;
    logic              res_valid;
    logic [ADDR_W-1:0] res_index;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  start, prime_valid, prime_data, core_proc_done,
               core_cs_out, core_add_out, core_data_out, res_ready,
        output prime_ready, core_cs_in, core_add_in, core_data_in,
               res_valid, res_index, res_data, busy, done, err
    );

    modport master (
        output start, prime_valid, prime_data, core_proc_done,
               core_cs_out, core_add_out, core_data_out, res_ready,
        input  prime_ready, core_cs_in, core_add_in, core_data_in,
               res_valid, res_index, res_data, busy, done, err
    );
endinterface

// File: rtl/gatebach_feeder.sv
// Loads one prime per gatebach_core, waits for sieving, buffers the result slice
// and streams it back to the host under valid/ready.
//  state       | meaning
//  S_IDLE      | waiting for start
//  S_LOAD      | accepting primes, writing one per core
//  S_WAIT_PROC | waiting for core_proc_done (watchdog armed)
//  S_COLLECT   | capturing result words from core output bus (watchdog armed)
//  S_DRAIN     | streaming buffered words to host
module gatebach_feeder #(
    parameter int CORE_NUM = 100,
    parameter int WORD_NUM = 100,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 65535
) (
    input  logic              clk,
    input  logic              sys_rst,
    gatebach_feeder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_PROC,
        S_COLLECT,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] CORE_LAST = ADDR_W'(CORE_NUM - 1);
    localparam logic [ADDR_W-1:0] WORD_LIM  = ADDR_W'(WORD_NUM);
    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(WORD_NUM - 1);
    localparam logic [15:0]       WD_LOAD   = 16'(TIMEOUT - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_load_cnt;
    logic [ADDR_W-1:0] r_cap_cnt;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [15:0]       r_wdog;
    logic              r_prime_ready;
    logic              r_core_cs_in;
    logic [ADDR_W-1:0] r_core_add_in;
    logic [DATA_W-1:0] r_core_data_in;
    logic              r_res_valid;
    logic [DATA_W-1:0] r_res_data;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_buf [WORD_NUM];

    logic              w_accept;
    logic              w_cap_en;
    logic              w_wd_expired;
    logic [ADDR_W-1:0] w_cap_idx;
    logic [ADDR_W-1:0] w_rd_next;

    assign w_accept     = (r_state == S_LOAD) && bus.prime_valid && r_prime_ready;
    assign w_wd_expired = (r_wdog == 16'd0);
    // Output address leads the data word by one, so address 0 carries nothing.
    assign w_cap_idx    = bus.core_add_out - ADDR_W'(1);
    assign w_cap_en     = (r_state == S_COLLECT) && (r_cap_cnt != WORD_LIM) && !w_wd_expired
                          && bus.core_cs_out && (bus.core_add_out != '0)
                          && (bus.core_add_out <= WORD_LIM);
    assign w_rd_next    = r_rd_ptr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (w_cap_en) begin
            r_buf[w_cap_idx] <= bus.core_data_out;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state        <= S_IDLE;
            r_load_cnt     <= '0;
            r_cap_cnt      <= '0;
            r_rd_ptr       <= '0;
            r_wdog         <= '0;
            r_prime_ready  <= 1'b0;
            r_core_cs_in   <= 1'b0;
            r_core_add_in  <= '0;
            r_core_data_in <= '0;
            r_res_valid    <= 1'b0;
            r_res_data     <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_core_cs_in <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse belongs to the old job.
                    if (bus.start && !r_done) begin
                        r_state       <= S_LOAD;
                        r_load_cnt    <= '0;
                        r_err         <= 1'b0;
                        r_prime_ready <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_core_cs_in   <= 1'b1;
                        r_core_add_in  <= r_load_cnt;
                        r_core_data_in <= bus.prime_data;
                        r_load_cnt     <= r_load_cnt + ADDR_W'(1);
                        if (r_load_cnt == CORE_LAST) begin
                            r_prime_ready <= 1'b0;
                            r_wdog        <= WD_LOAD;
                            r_state       <= S_WAIT_PROC;
                        end
                    end
                end
                S_WAIT_PROC: begin
                    if (bus.core_proc_done) begin
                        r_state   <= S_COLLECT;
                        r_wdog    <= WD_LOAD;
                        r_cap_cnt <= '0;
                    end else if (w_wd_expired) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog - 16'd1;
                    end
                end
                S_COLLECT: begin
                    if (r_cap_cnt == WORD_LIM) begin
                        r_state     <= S_DRAIN;
                        r_rd_ptr    <= '0;
                        r_res_valid <= 1'b1;
                        r_res_data  <= r_buf[0];
                    end else if (w_wd_expired) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog - 16'd1;
                        if (w_cap_en) begin
                            r_cap_cnt <= r_cap_cnt + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.res_ready) begin
                        if (r_rd_ptr == WORD_LAST) begin
                            r_state     <= S_IDLE;
                            r_res_valid <= 1'b0;
                            r_res_data  <= '0;
                            r_rd_ptr    <= '0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_rd_ptr   <= w_rd_next;
                            r_res_data <= r_buf[w_rd_next];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prime_ready  = r_prime_ready;
    assign bus.core_cs_in   = r_core_cs_in;
    assign bus.core_add_in  = r_core_add_in;
    assign bus.core_data_in = r_core_data_in;
    assign bus.res_valid    = r_res_valid;
    assign bus.res_index    = r_rd_ptr;
    assign bus.res_data     = r_res_data;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;

endmodule

// File: tb/tb_gatebach_feeder.sv
// Directed bench for gatebach_feeder: table-driven load vectors plus hand-written
// sequences for reset, collection, drain stalls and watchdog timeout.
module tb_gatebach_feeder;

    localparam int CORE_NUM = 100;
    localparam int WORD_NUM = 100;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 32;
    localparam int TIMEOUT  = 1000;

    typedef struct {
        bit          valid;
        logic [31:0] data;
        bit          proc_done;
        bit          exp_cs;
        logic [31:0] exp_add;
        logic [31:0] exp_data;
        bit          exp_ready;
    } vec_t;

    logic clk = 1'b0;
    logic sys_rst;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] primes [CORE_NUM];
    vec_t vt [2*CORE_NUM];

    always #5 clk = ~clk;

    gatebach_feeder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    gatebach_feeder #(
        .CORE_NUM(CORE_NUM),
        .WORD_NUM(WORD_NUM),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_ready", bus.prime_ready, 1);
        chk("start_err", bus.err, 0);
    endtask

    task automatic load_b2b(input int n);
        for (int i = 0; i < n; i++) begin
            bus.prime_valid = 1'b1;
            bus.prime_data  = primes[i];
            tick;
            chk("load_cs", bus.core_cs_in, 1);
            chk("load_add", bus.core_add_in, i);
            chk("load_data", bus.core_data_in, primes[i]);
            chk("load_ready", bus.prime_ready, (i == CORE_NUM-1) ? 0 : 1);
        end
        bus.prime_valid = 1'b0;
        bus.prime_data  = '0;
    endtask

    task automatic core_drv(input bit cs, input int a, input logic [31:0] d);
        bus.core_cs_out   = cs;
        bus.core_add_out  = a[ADDR_W-1:0];
        bus.core_data_out = d;
        tick;
    endtask

    task automatic collect(input logic [31:0] base);
        bus.core_proc_done = 1'b1;
        tick;
        bus.core_proc_done = 1'b0;
        chk("collect_busy", bus.busy, 1);
        // Out-of-range or idle-bus words go first so a bad count would cut the slice short.
        core_drv(1'b1, 0,   32'hBAD0_0000);
        core_drv(1'b1, 101, 32'hBAD0_0065);
        core_drv(1'b0, 5,   32'hBAD0_0005);
        core_drv(1'b1, 127, 32'hBAD0_007F);
        for (int a = 1; a <= WORD_NUM; a++) begin
            if (a % 10 == 0) core_drv(1'b0, a, 32'hBAD1_0000 + a);
            core_drv(1'b1, a, base + a - 1);
        end
        bus.core_cs_out   = 1'b0;
        bus.core_add_out  = '0;
        bus.core_data_out = '0;
    endtask

    task automatic drain(input logic [31:0] base, input int stall_idx);
        int waited = 0;
        bus.res_ready = 1'b0;
        while (!bus.res_valid && waited < 20) begin
            tick;
            waited++;
        end
        chk("drain_start_valid", bus.res_valid, 1);
        if (bus.res_valid) begin
            for (int e = 0; e < WORD_NUM; e++) begin
                chk("res_valid", bus.res_valid, 1);
                chk("res_index", bus.res_index, e);
                chk("res_data", bus.res_data, base + e);
                chk("done_early", bus.done, 0);
                if (e == stall_idx) begin
                    bus.res_ready = 1'b0;
                    for (int s = 0; s < 5; s++) begin
                        tick;
                        chk("stall_valid", bus.res_valid, 1);
                        chk("stall_index", bus.res_index, e);
                        chk("stall_data", bus.res_data, base + e);
                    end
                end
                bus.res_ready = 1'b1;
                tick;
            end
            bus.res_ready = 1'b0;
            chk("done_pulse", bus.done, 1);
            chk("drain_end_valid", bus.res_valid, 0);
            chk("drain_end_busy", bus.busy, 0);
            // start alongside the done pulse must not launch a job
            bus.start = 1'b1;
            tick;
            bus.start = 1'b0;
            chk("done_start_ignored", bus.busy, 0);
            chk("done_one_cycle", bus.done, 0);
            tick;
            chk("idle_busy", bus.busy, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p;
        int n;
        bit is_p;
        p = 2;
        n = 0;
        while (n < CORE_NUM) begin
            is_p = 1'b1;
            for (int d = 2; d * d <= p; d++) if (p % d == 0) is_p = 1'b0;
            if (is_p) begin
                primes[n] = p;
                n++;
            end
            p++;
        end
        for (int i = 0; i < 2*CORE_NUM; i++) begin
            vt[i].valid     = (i % 2 == 0);
            vt[i].data      = vt[i].valid ? primes[i/2] : 32'hDEAD_0000 + i;
            vt[i].proc_done = (i < 10);
            vt[i].exp_cs    = vt[i].valid;
            vt[i].exp_add   = i / 2;
            vt[i].exp_data  = primes[i/2];
            vt[i].exp_ready = (i < 2*CORE_NUM - 2);
        end

        bus.start = 1'b0;          bus.prime_valid = 1'b0;   bus.prime_data = '0;
        bus.core_proc_done = 1'b0; bus.core_cs_out = 1'b0;   bus.core_add_out = '0;
        bus.core_data_out = '0;    bus.res_ready = 1'b0;
        sys_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_prime_ready", bus.prime_ready, 0);
        chk("rst_cs_in", bus.core_cs_in, 0);
        chk("rst_add_in", bus.core_add_in, 0);
        chk("rst_data_in", bus.core_data_in, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_index", bus.res_index, 0);
        chk("rst_res_data", bus.res_data, 0);
        sys_rst = 1'b0;
        tick;

        // Reset in the middle of LOAD
        do_start;
        load_b2b(40);
        bus.prime_valid = 1'b1;
        bus.prime_data  = 32'd12345;
        sys_rst = 1'b1;
        #1;
        chk("midrst_cs_in", bus.core_cs_in, 0);
        chk("midrst_add_in", bus.core_add_in, 0);
        chk("midrst_data_in", bus.core_data_in, 0);
        chk("midrst_ready", bus.prime_ready, 0);
        chk("midrst_busy", bus.busy, 0);
        tick;
        sys_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("postrst_cs_in", bus.core_cs_in, 0);
            chk("postrst_ready", bus.prime_ready, 0);
            chk("postrst_busy", bus.busy, 0);
        end
        bus.prime_valid = 1'b0;

        // Full job: back-to-back primes, then collect and drain with a stall at word 17
        do_start;
        load_b2b(CORE_NUM);
        bus.prime_valid = 1'b1;
        bus.prime_data  = 32'd999;
        tick;
        chk("post_load_cs", bus.core_cs_in, 0);
        chk("post_load_ready", bus.prime_ready, 0);
        chk("post_load_busy", bus.busy, 1);
        bus.prime_valid = 1'b0;
        collect(32'hA500_0000);
        drain(32'hA500_0000, 17);

        // Table-driven load with prime_valid toggling and an early core_proc_done
        do_start;
        for (int i = 0; i < 2*CORE_NUM; i++) begin
            bus.prime_valid    = vt[i].valid;
            bus.prime_data     = vt[i].data;
            bus.core_proc_done = vt[i].proc_done;
            tick;
            chk("tbl_cs", bus.core_cs_in, vt[i].exp_cs);
            if (vt[i].exp_cs) begin
                chk("tbl_add", bus.core_add_in, vt[i].exp_add);
                chk("tbl_data", bus.core_data_in, vt[i].exp_data);
            end
            chk("tbl_ready", bus.prime_ready, vt[i].exp_ready);
        end
        bus.prime_valid    = 1'b0;
        bus.core_proc_done = 1'b0;
        collect(32'h5A00_0000);
        drain(32'h5A00_0000, -1);

        // Watchdog: core_proc_done never arrives
        do_start;
        load_b2b(CORE_NUM);
        repeat (TIMEOUT - 1) tick;
        chk("wd_err_before", bus.err, 0);
        chk("wd_busy_before", bus.busy, 1);
        tick;
        chk("wd_err", bus.err, 1);
        chk("wd_busy", bus.busy, 0);
        chk("wd_no_done", bus.done, 0);
        repeat (3) tick;
        chk("wd_err_sticky", bus.err, 1);
        do_start;

        sys_rst = 1'b1;
        tick;
        sys_rst = 1'b0;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
